// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if
// Request/result bus of the nibble-serial ALU sequencer.
//   start       : operation request (requester -> sequencer)
//   A, B        : WIDTH-bit operands
//   S           : 4-bit function select
//   M_inverse   : 1 = arithmetic, 0 = logic
//   Ci_inverse  : carry-in into bit 0 (1 = carry)
//   busy        : sequencer is in RUN or DONE
//   done        : one-cycle completion pulse, F/Co valid from this cycle
//   F           : WIDTH-bit result
//   Co          : carry out of the MSB nibble
// The requester side uses the master modport, the sequencer the slave modport.
interface alu_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       S;
  logic             M_inverse;
  logic             Ci_inverse;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] F;
  logic             Co;

  modport master (
    output start, A, B, S, M_inverse, Ci_inverse,
    input  busy, done, F, Co
  );

  modport slave (
    input  start, A, B, S, M_inverse, Ci_inverse,
    output busy, done, F, Co
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Drives an external 4-bit carry-lookahead slice one operand nibble per cycle
// so that a single slice performs WIDTH-bit add, subtract and logic operations
// over WIDTH/4 cycles. The carry between nibbles is held in a register.
// Ports:
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   bus              : request/result bus (slave modport)
//   la_p_o, la_g_o   : propagate/generate of the current nibble
//   la_Ci_inverse_o  : carry-in of the current nibble
//   la_M_inverse_o   : latched arithmetic/logic mode
//   la_o_i           : active-low lookahead carries returned by the slice
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_nibble_sequencer_if.slave bus,
  output logic [3:0]            la_p_o,
  output logic [3:0]            la_g_o,
  output logic                  la_Ci_inverse_o,
  output logic                  la_M_inverse_o,
  input  logic [3:0]            la_o_i
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [3:0]        s_q, s_d;
  logic              m_q, m_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  f_q, f_d;
  logic              co_q, co_d;

  logic [IDXW+1:0]   nibShift;
  logic [WIDTH-1:0]  aShifted;
  logic [WIDTH-1:0]  bShifted;
  logic [3:0]        aNib;
  logic [3:0]        bNib;
  logic [3:0]        pNib;
  logic [3:0]        gNib;
  logic [3:0]        hNib;
  logic [3:0]        bitCarry;
  logic              nibCarryOut;
  logic [WIDTH-1:0]  fMerged;
  logic              lastNib;

  // Select the current operand nibble by shifting it down to bit 0.
  assign nibShift = {idx_q, 2'b00};
  assign aShifted = a_q >> nibShift;
  assign bShifted = b_q >> nibShift;
  assign aNib     = aShifted[3:0];
  assign bNib     = bShifted[3:0];

  assign pNib = aNib | (bNib & {4{s_q[0]}}) | (~bNib & {4{s_q[1]}});
  assign gNib = (aNib & ~bNib & {4{s_q[2]}}) | (aNib & bNib & {4{s_q[3]}});
  assign hNib = pNib & ~gNib;

  // Bit carries come back active-low from the slice; logic mode forces them
  // to 0 regardless of what the slice reports.
  assign bitCarry    = {~la_o_i[2:0] & {3{m_q}}, c_q & m_q};
  assign nibCarryOut = m_q & (~la_o_i[3] | (&pNib & c_q));

  // Replace only the current nibble of the result register.
  assign fMerged = (f_q & ~(WIDTH'(4'hF) << nibShift))
                 | (WIDTH'(hNib ^ bitCarry) << nibShift);

  assign lastNib = (idx_q == IDXW'(NIB - 1));

  assign la_p_o          = pNib;
  assign la_g_o          = gNib;
  assign la_Ci_inverse_o = c_q;
  assign la_M_inverse_o  = m_q;

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.F    = f_q;
  assign bus.Co   = co_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      c_q     <= 1'b0;
      f_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      c_q     <= c_d;
      f_q     <= f_d;
      co_q    <= co_d;
    end
  end

  // Next-state logic: accept in IDLE, one nibble per RUN cycle, one DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    c_d     = c_q;
    f_d     = f_q;
    co_d    = co_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          s_d     = bus.S;
          m_d     = bus.M_inverse;
          c_d     = bus.Ci_inverse & bus.M_inverse;
          f_d     = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        f_d = fMerged;
        c_d = nibCarryOut;
        if (lastNib) begin
          co_d    = nibCarryOut;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Nibble-serial control stage for the ALU. It wraps the 4-bit carry-lookahead sub-module and drives its `p`, `g`, `Ci_inverse` and `M_inverse` inputs one operand nibble per cycle. It consumes the returned active-low `o[3:0]`, assembles a WIDTH-bit result and carries between nibbles in a register. It lets one 4-bit lookahead slice execute WIDTH-bit add, subtract and logic operations over WIDTH/4 cycles.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of 4, min 4. NIB = WIDTH/4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE.
- `A`, `B`  in  WIDTH  operands, sampled on accept.
- `S`  in  4  function select, sampled on accept.
- `M_inverse`  in  1  1 = arithmetic (carries enabled), 0 = logic. Sampled on accept.
- `Ci_inverse`  in  1  carry-in into bit 0 (1 = carry). Sampled on accept.
- `la_p`, `la_g`  out  4  propagate/generate of current nibble, to the lookahead sub-module.
- `la_Ci_inverse`  out  1  current nibble carry-in, to the sub-module.
- `la_M_inverse`  out  1  latched mode, to the sub-module.
- `la_o`  in  4  active-low lookahead outputs returned by the sub-module (combinational, same cycle).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `F` and `Co` are valid from this cycle.
- `F`  out  WIDTH  result.
- `Co`  out  1  carry out of MSB nibble; 0 in logic mode.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, `idx`=0, all latches 0, `F`=0, `Co`=0, `done`=0, `busy`=0. Outputs `la_*` are driven from zeroed registers, so all are 0.
- IDLE, `start`=1: latch `A`, `B`, `S`, `M_inverse`. Load carry register c = `Ci_inverse & M_inverse`. Clear `F` to 0, set `idx`=0, go to RUN.
- Per-bit terms for the current nibble (a = A[4idx+i], b = B[4idx+i]):
  - p_i = a | (b&S0) | (~b&S1)
  - g_i = (a&~b&S2) | (a&b&S3)
  - h_i = p_i & ~g_i
- Outputs to the sub-module: `la_p`=p, `la_g`=g, `la_Ci_inverse`=c, `la_M_inverse`=latched mode.
- Bit carries: c0 = c; c1..c3 = ~`la_o[0]`, ~`la_o[1]`, ~`la_o[2]`. In logic mode all bit carries are 0.
- Result bits: F[4idx+i] = h_i ^ c_i, written at the end of each RUN cycle.
- Nibble carry-out: co = ~`la_o[3]` | (p0&p1&p2&p3&c). It is gated by mode: co is 0 when `M_inverse`=0. Register c <= co.
- RUN: if `idx`=NIB-1, set `Co` <= co and go to DONE. Otherwise `idx` <= `idx`+1.
- DONE: `done`=1 for this cycle only, `busy`=1. The next state is always IDLE.
- Common selects:
  - S=1001, M=1: A plus B plus Ci.
  - S=0110, M=1, Ci=1: A minus B; `Co`=1 means no borrow.
  - S=1001, M=0: A xor B.

## Timing
- `start` sampled at edge T0. RUN occupies cycles T0+1 … T0+NIB. `done` is high in cycle T0+NIB+1; this is 5 cycles after the accept for WIDTH=16.
- Throughput: one operation per NIB+2 cycles. A `start` in DONE is ignored; the next accept is possible in IDLE.
- `start` in RUN/DONE is ignored, with no queueing. Operand inputs may change freely after accept.
- `F` and `Co` hold their values from DONE until the next accept, which clears `F`. Partial `F` is visible during RUN but not valid.
- The `la_o` path is combinational within the cycle: la_p/la_g → sub-module → la_o → F/c registers.
- `rst_n` low at any time, including mid-RUN, immediately forces the reset state. No `done` is produced for the aborted operation.

## Test plan
- WIDTH=16, S=1001, M=1, Ci=0, A=0x1234, B=0x0FCD → `done` at T0+5, F=0x2201, Co=0; `busy` high T0+1…T0+5.
- S=1001, M=1, Ci=0, A=0xFFFF, B=0x0001 → F=0x0000, Co=1. Carry ripples through all four nibble registers.
- S=0110, M=1, Ci=1, A=0x5000, B=0x0001 → F=0x4FFF, Co=1. Then A=0x0000, B=0x0001 → F=0xFFFF, Co=0.
- S=1001, M=0, Ci=1, A=0xF0F0, B=0xFF00 → F=0x0FF0, Co=0; `la_Ci_inverse` and `la_M_inverse` are 0 throughout.
- `start` held high with a different A during RUN → ignored; the first result is unchanged and exactly one `done` pulse occurs per accepted operation.
- `rst_n` pulsed low in cycle T0+2 → IDLE, F=0, Co=0, busy=0, no `done`. A new `start` afterwards completes normally.
